// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for a shared serial bus with grant-idle timeout
// and a one-cycle GAP that drives slave_busy between grants.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   b_bus_utilizing,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic [2:0]             grant_id,
  output logic                   grant_valid,
  output logic                   slv_bsy_drive,
  output logic                   slv_bsy_out,
  output logic                   timeout_evt
);
  typedef enum logic [1:0] {IDLE, GRANTED, ACTIVE, GAP} state_t;
  state_t                   state;
  logic [2:0]               ptr, off, win;
  logic [3:0]               sum;
  logic [TIMEOUT_LEN-1:0]   cnt;
  logic [2*NUM_MASTERS-1:0] rot_full;
  logic [NUM_MASTERS-1:0]   rot;
  logic                     held, rel, tout;
  assign slv_bsy_out = 1'b1;
  // Rotate requests so ptr sits at bit 0; the lowest set bit is the winner's offset.
  always_comb begin
    rot_full = {b_request, b_request} >> ptr;
    rot = rot_full[NUM_MASTERS-1:0];
    off = '0;
    for (int k = NUM_MASTERS-1; k >= 0; k--)
      if (rot[k]) off = 3'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= 4'(NUM_MASTERS)) ? 3'(sum - 4'(NUM_MASTERS)) : sum[2:0];
    held = |(b_request & b_grant);
    tout = state == GRANTED && !b_bus_utilizing && held && cnt == '1;
    rel = !b_bus_utilizing && ((state == GRANTED && (!held || cnt == '1)) || (state == ACTIVE && !held));
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      b_grant       <= '0;
      grant_id      <= '0;
      grant_valid   <= 1'b0;
      slv_bsy_drive <= 1'b0;
      timeout_evt   <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      timeout_evt   <= tout;
      slv_bsy_drive <= rel;
      if (rel) begin
        b_grant     <= '0;
        grant_valid <= 1'b0;
        state       <= GAP;
      end else begin
        case (state)
          IDLE: if (|b_request) begin
            b_grant     <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
            grant_id    <= win;
            grant_valid <= 1'b1;
            ptr         <= (win == 3'(NUM_MASTERS-1)) ? 3'd0 : win + 3'd1;
            cnt         <= '0;
            state       <= GRANTED;
          end
          GRANTED: if (b_bus_utilizing) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
          ACTIVE: if (!b_bus_utilizing) begin
            state <= GRANTED;
            cnt   <= '0;
          end
          GAP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus random traffic, checked against a
// behavioural owner/round-robin model of the arbiter.
module tb_bus_arbiter;
  localparam int N = 3, TL = 6, LIM = 1 << TL;
  logic clk = 0, rstn = 0, util = 0;
  logic [N-1:0] b_request = '0, b_grant;
  logic [2:0] grant_id;
  logic grant_valid, slv_bsy_drive, slv_bsy_out, timeout_evt;
  int total = 0, bad = 0;
  int owner = -1, rr = 0, idle = 0;
  bit busy = 0, gap = 0, tevt = 0;
  always #5 clk = ~clk;
  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_LEN(TL)) dut (
    .clk(clk), .rstn(rstn), .b_request(b_request), .b_bus_utilizing(util),
    .b_grant(b_grant), .grant_id(grant_id), .grant_valid(grant_valid),
    .slv_bsy_drive(slv_bsy_drive), .slv_bsy_out(slv_bsy_out), .timeout_evt(timeout_evt));
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    owner = -1; rr = 0; idle = 0; busy = 0; gap = 0; tevt = 0;
  endfunction
  // One clock edge of the model: owner is the granted master or -1; idle counts
  // low-utilisation edges since the grant or since utilisation last fell.
  function automatic void model_edge();
    tevt = 0;
    if (gap) gap = 0;
    else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int m;
        m = (rr + k) % N;
        if (b_request[m]) begin
          owner = m; rr = (m + 1) % N; idle = 0; busy = 0;
          break;
        end
      end
    end else if (util) begin busy = 1; idle = 0; end
    else if (!b_request[owner]) begin owner = -1; gap = 1; end
    else if (busy) begin busy = 0; idle = 0; end
    else begin
      idle++;
      if (idle == LIM) begin owner = -1; gap = 1; tevt = 1; end
    end
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_gnt"}, b_grant, 0);
    chk({tag, "_id"}, grant_id, 0);
    chk({tag, "_vld"}, grant_valid, 0);
    chk({tag, "_drv"}, slv_bsy_drive, 0);
    chk({tag, "_out"}, slv_bsy_out, 1);
    chk({tag, "_tevt"}, timeout_evt, 0);
  endtask
  task automatic step(input string tag);
    logic [N-1:0] prev;
    logic hold;
    prev = b_grant;
    hold = util && grant_valid;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_gnt"}, b_grant, owner < 0 ? 0 : (1 << owner));
    chk({tag, "_vld"}, grant_valid, owner >= 0);
    if (owner >= 0) chk({tag, "_id"}, grant_id, owner);
    chk({tag, "_drv"}, slv_bsy_drive, gap);
    chk({tag, "_out"}, slv_bsy_out, 1);
    chk({tag, "_tevt"}, timeout_evt, tevt);
    chk({tag, "_onehot"}, $onehot0(b_grant), 1);
    if (hold) chk({tag, "_hold"}, b_grant, prev);
  endtask
  task automatic do_reset(input string tag);
    #2 rstn = 0;
    #1 model_reset();
    check_reset(tag);
    @(posedge clk);
    #1 rstn = 1;
  endtask
  initial begin
    logic [N-1:0] order[$];
    int ph, cycles;
    @(posedge clk);
    #1 check_reset("rst0");
    rstn = 1;
    // single requester
    b_request = 3'b010;
    step("s_req");
    chk("s_gnt", b_grant, 3'b010);
    util = 1;
    step("s_act");
    step("s_act2");
    util = 0; b_request = 0;
    step("s_rel");
    chk("s_gap_gnt", b_grant, 0);
    chk("s_gap_drv", slv_bsy_drive, 1);
    step("s_idle");
    chk("s_idle_drv", slv_bsy_drive, 0);
    // contention after reset
    do_reset("rst1");
    b_request = 3'b111; ph = 0;
    for (int i = 0; i < 100 && order.size() < 4; i++) begin
      step("rr");
      if (ph == 0 && grant_valid) begin order.push_back(b_grant); util = 1; ph = 1; end
      else if (ph == 1) ph = 2;
      else if (ph == 2) begin util = 0; b_request = 3'b111 & ~b_grant; ph = 3; end
      else if (ph == 3) begin b_request = 3'b111; ph = 0; end
    end
    chk("rr_count", order.size(), 4);
    while (order.size() < 4) order.push_back('0);
    chk("rr_0", order[0], 3'b001);
    chk("rr_1", order[1], 3'b010);
    chk("rr_2", order[2], 3'b100);
    chk("rr_3", order[3], 3'b001);
    util = 0; b_request = 0;
    repeat (3) step("rr_end");
    // timeout on master 2
    b_request = 3'b100;
    step("to_gnt");
    chk("to_gnt2", b_grant, 3'b100);
    cycles = 0;
    for (int i = 0; i < 100 && !timeout_evt; i++) begin
      step("to_wait");
      cycles++;
    end
    chk("to_seen", timeout_evt, 1);
    chk("to_len", cycles, LIM);
    chk("to_revoked", b_grant, 0);
    b_request = 3'b101;
    step("to_gap");
    chk("to_pulse", timeout_evt, 0);
    step("to_next");
    chk("to_next_m0", b_grant, 3'b001);
    b_request = 0;
    repeat (3) step("to_end");
    // request dropped while utilising
    b_request = 3'b010;
    step("d_gnt");
    util = 1;
    step("d_act");
    b_request = 0;
    repeat (3) begin
      step("d_hold");
      chk("d_held", grant_valid, 1);
    end
    util = 0;
    step("d_rel");
    chk("d_released", grant_valid, 0);
    step("d_idle");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      b_request = N'($urandom_range(0, (1 << N) - 1));
      util = ($urandom_range(0, 9) < 4);
      step("rnd");
    end
    util = 0; b_request = 0;
    repeat (3) step("rnd_end");
    // reset during ACTIVE
    b_request = 3'b010;
    step("a_gnt");
    util = 1;
    step("a_act");
    chk("a_active", grant_valid, 1);
    #3 rstn = 0;
    #1 model_reset();
    check_reset("a_rst");
    @(posedge clk);
    #1 rstn = 1;
    util = 0; b_request = 3'b111;
    step("a_first");
    chk("a_first_m0", b_grant, 3'b001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
